// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//   - arb_state_t : owner of the read response due in the current cycle
//   - GNT_CPU / GNT_LD : requester ids used by the round-robin pointer
//   - RW_* : access size/sign codes shared with the core's control unit;
//            the arbiter forwards them untouched to the RAM
//   - arb_dbg_t : packed view of internal state for checkers and probes
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_RESP = 2'd1,
    ST_LD_RESP  = 2'd2
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef struct packed {
    arb_state_t state;
    logic       last_gnt;
    logic       gnt_cpu;
    logic       gnt_ld;
  } arb_dbg_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous single-port data RAM (1-cycle read latency)
//   between the single-cycle core's load/store port and a loader/debug
//   master. Two-way round-robin on conflict; cpu_stall holds the core's PC
//   while its load is outstanding or while it has lost arbitration.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cpu_r_en/cpu_w_en : core load/store request (both set = store)
//   cpu_addr/wdata    : core address and store data
//   cpu_rw_type       : core access size/sign, forwarded to RAM
//   cpu_rdata         : load data, valid in the response cycle (else 0)
//   cpu_stall         : core must hold PC and register writeback
//   ld_req/we/addr/wdata/rw_type : loader command
//   ld_gnt            : loader command accepted this cycle
//   ld_rvalid/ld_rdata: loader read response pulse and data
//   mem_*             : RAM command (all zero when nothing is granted)
//   mem_rdata         : RAM read data, valid the cycle after a read
//   dbg               : internal state for probes
//
// Handshake: the loader holds ld_req and its command stable until it sees
//   ld_gnt high at a rising edge; that edge transfers the command. ld_gnt is
//   combinational and coincides with mem_en for that command. The loader
//   must drop or change its request after the grant edge. Read data comes
//   back as a single ld_rvalid pulse in the following cycle; there is no
//   back-pressure on responses. The core instead holds its request while
//   cpu_stall is high; a request seen while its own response is being
//   delivered belongs to the instruction completing and is not re-issued.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_r_en,
  input  logic              cpu_w_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_rw_type,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [2:0]        ld_rw_type,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_rw_type,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_dbg_t          dbg
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_gnt_q;

  logic cpu_req;
  logic cpu_elig;
  logic ld_elig;
  logic gnt_cpu;
  logic gnt_ld;

  // Arbitration. The core is not eligible while its own read response is
  // being returned: that request is the same instruction finishing. All
  // grants are suppressed while rst is high so outputs stay quiet.
  always_comb begin
    cpu_req  = cpu_r_en | cpu_w_en;
    cpu_elig = cpu_req && (state_q != ST_CPU_RESP) && !rst;
    ld_elig  = ld_req && !rst;
    gnt_cpu  = 1'b0;
    gnt_ld   = 1'b0;
    if (cpu_elig && ld_elig) begin
      // Conflict: the requester that did not win last time goes first.
      if (last_gnt_q == GNT_LD) begin
        gnt_cpu = 1'b1;
      end else begin
        gnt_ld = 1'b1;
      end
    end else begin
      gnt_cpu = cpu_elig;
      gnt_ld  = ld_elig;
    end
  end

  // Response-owner FSM: next state depends only on what is granted now, so
  // a new command can issue in the response cycle of the previous read.
  always_comb begin
    state_d = ST_IDLE;
    if (gnt_cpu && !cpu_w_en) begin
      state_d = ST_CPU_RESP;
    end else if (gnt_ld && !ld_we) begin
      state_d = ST_LD_RESP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_LD;
    end else begin
      state_q <= state_d;
      if (gnt_cpu) begin
        last_gnt_q <= GNT_CPU;
      end else if (gnt_ld) begin
        last_gnt_q <= GNT_LD;
      end
    end
  end

  // RAM command mux.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rw_type = '0;
    if (gnt_cpu) begin
      mem_en      = 1'b1;
      mem_we      = cpu_w_en;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_rw_type = cpu_rw_type;
    end else if (gnt_ld) begin
      mem_en      = 1'b1;
      mem_we      = ld_we;
      mem_addr    = ld_addr;
      mem_wdata   = ld_wdata;
      mem_rw_type = ld_rw_type;
    end
  end

  // Requester-side outputs. A granted core store completes with zero wait;
  // a granted core load stalls one cycle until its data returns.
  always_comb begin
    ld_gnt    = gnt_ld;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    ld_rvalid = 1'b0;
    ld_rdata  = '0;
    if (!rst) begin
      if (state_q != ST_CPU_RESP) begin
        cpu_stall = cpu_req && (!gnt_cpu || !cpu_w_en);
      end
      if (state_q == ST_CPU_RESP) begin
        cpu_rdata = mem_rdata;
      end
      if (state_q == ST_LD_RESP) begin
        ld_rvalid = 1'b1;
        ld_rdata  = mem_rdata;
      end
    end
  end

  always_comb begin
    dbg.state    = state_q;
    dbg.last_gnt = last_gnt_q;
    dbg.gnt_cpu  = gnt_cpu;
    dbg.gnt_ld   = gnt_ld;
  end

endmodule
